cp0: RTL and testbench

CP0 -- requirements
Module: cp0

---
 rtl/cp0.sv | 120 ++++++++++++
 tb/tb_cp0.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// rtl/cp0.sv - MIPS-style coprocessor 0: SR/Cause/EPC, exception entry and eret
// Optional Count/Compare timer enabled by defining CP0_COUNT_EN.
module cp0 #(
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic        exc_vld,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc;
    logic [5:0]  ip_live;
    logic [5:0]  ip_read;
    logic        int_req;
    logic        wr;

`ifdef CP0_COUNT_EN
    logic [31:0] count;
    logic [31:0] compare;
    logic        timer_pend;

    // The timer shares interrupt line 5 with the external hw_int[5].
    assign ip_live = hw_int | {timer_pend, 5'b0};
    assign ip_read = cause_ip | {timer_pend, 5'b0};
`else
    assign ip_live = hw_int;
    assign ip_read = cause_ip;
`endif

    assign int_req    = (|(ip_live & sr_im)) & sr_ie & ~sr_exl;
    assign req        = int_req | (exc_vld & ~sr_exl);
    assign wr         = en & ~req;
    assign handler_pc = EXC_ENTRY;
    // Forward an mtc0 EPC write so an eret in the same cycle returns to it.
    assign epc_out    = (en && cp0_addr == 5'd14) ? cp0_in : epc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                sr_exl    <= 1'b1;
                cause_bd  <= bd_in;
                epc       <= bd_in ? (vpc - 32'd4) : vpc;
                cause_exc <= int_req ? 5'd0 : exc_code;
            end else begin
                if (eret)
                    sr_exl <= 1'b0;
                if (wr && cp0_addr == 5'd12) begin
                    sr_im  <= cp0_in[15:10];
                    sr_exl <= cp0_in[1];
                    sr_ie  <= cp0_in[0];
                end
                if (wr && cp0_addr == 5'd14)
                    epc <= cp0_in;
            end
        end
    end

`ifdef CP0_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            compare    <= '0;
            timer_pend <= 1'b0;
        end else begin
            if (wr && cp0_addr == 5'd9)
                count <= cp0_in;
            else
                count <= count + 32'd1;
            if (wr && cp0_addr == 5'd11) begin
                compare    <= cp0_in;
                timer_pend <= 1'b0;
            end else if (count == compare) begin
                timer_pend <= 1'b1;
            end
        end
    end
`endif

    always_comb begin
        cp0_out = '0;
        case (cp0_addr)
            5'd12:   cp0_out = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
            5'd13:   cp0_out = {cause_bd, 15'b0, ip_read, 3'b0, cause_exc, 2'b0};
            5'd14:   cp0_out = epc;
`ifdef CP0_COUNT_EN
            5'd9:    cp0_out = count;
            5'd11:   cp0_out = compare;
`endif
            default: cp0_out = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - scoreboard testbench for cp0
module tb_cp0;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic        exc_vld;
    logic [4:0]  exc_code;
    logic [5:0]  hw_int;
    logic        eret;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;

    localparam int SEL_REQ = 0, SEL_OUT = 1, SEL_EPC = 2, SEL_HPC = 3;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic got;

    cp0 dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cp0_addr   (cp0_addr),
        .cp0_in     (cp0_in),
        .cp0_out    (cp0_out),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_vld    (exc_vld),
        .exc_code   (exc_code),
        .hw_int     (hw_int),
        .eret       (eret),
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.sel)
                SEL_REQ: check(e.tag, {31'b0, req}, e.val);
                SEL_OUT: check(e.tag, cp0_out, e.val);
                SEL_EPC: check(e.tag, epc_out, e.val);
                default: check(e.tag, handler_pc, e.val);
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        en       = 1'b0;
        cp0_addr = 5'd0;
        cp0_in   = '0;
        vpc      = '0;
        bd_in    = 1'b0;
        exc_vld  = 1'b0;
        exc_code = '0;
        hw_int   = '0;
        eret     = 1'b0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        en       = 1'b1;
        cp0_addr = a;
        cp0_in   = d;
        step();
        en       = 1'b0;
        cp0_in   = '0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string tag);
        cp0_addr = a;
        expect_val(tag, SEL_OUT, exp);
        drain();
    endtask

    initial begin
        reset = 1'b0;
        idle();
        @(negedge clk);
        cp0_addr = 5'd12;
        expect_val("rst_sr", SEL_OUT, 32'h0);
        expect_val("rst_req", SEL_REQ, 32'h0);
        expect_val("rst_epc_out", SEL_EPC, 32'h0);
        expect_val("handler_pc", SEL_HPC, 32'h0000_4180);
        drain();
        rd(5'd13, 32'h0, "rst_cause");
        reset = 1'b1;
        step();

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, 32'h0000_0401, "sr_write");
        hw_int = 6'd1;
        vpc    = 32'h3000;
        expect_val("int_req", SEL_REQ, 32'h1);
        drain();
        step();
        idle();
        rd(5'd12, 32'h0000_0403, "int_exl");
        rd(5'd13, 32'h0000_0400, "int_cause");
        rd(5'd14, 32'h0000_3000, "int_epc");

        // mtc0 EPC forwarded to eret
        en = 1'b1; cp0_addr = 5'd14; cp0_in = 32'h3100; eret = 1'b1;
        expect_val("fwd_epc_out", SEL_EPC, 32'h3100);
        expect_val("fwd_req", SEL_REQ, 32'h0);
        drain();
        step();
        idle();
        rd(5'd12, 32'h0000_0401, "eret_exl");
        rd(5'd14, 32'h0000_3100, "eret_epc");

        // Exception in a delay slot
        exc_vld = 1'b1; exc_code = 5'd12; bd_in = 1'b1; vpc = 32'h3008;
        expect_val("ov_req", SEL_REQ, 32'h1);
        drain();
        step();
        idle();
        rd(5'd14, 32'h0000_3004, "bd_epc");
        rd(5'd13, 32'h8000_0030, "bd_cause");

        // No nested exceptions while EXL
        exc_vld = 1'b1; exc_code = 5'd4; hw_int = 6'h3F; vpc = 32'h5000;
        expect_val("nest_req", SEL_REQ, 32'h0);
        drain();
        step();
        idle();
        rd(5'd13, 32'h8000_FC30, "nest_cause");
        rd(5'd14, 32'h0000_3004, "nest_epc");
        eret = 1'b1;
        expect_val("eret_epc_out", SEL_EPC, 32'h0000_3004);
        drain();
        step();
        idle();
        rd(5'd12, 32'h0000_0401, "eret2_sr");

        // mtc0 dropped when req fires in the same cycle
        en = 1'b1; cp0_addr = 5'd12; cp0_in = 32'h0;
        exc_vld = 1'b1; exc_code = 5'd10; vpc = 32'h3010;
        expect_val("drop_req", SEL_REQ, 32'h1);
        drain();
        step();
        idle();
        rd(5'd12, 32'h0000_0403, "drop_sr");
        rd(5'd13, 32'h0000_0028, "drop_cause");
        rd(5'd14, 32'h0000_3010, "drop_epc");

        // Write masks and read-only registers
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "sr_mask");
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, 32'h0000_0028, "cause_ro");
        rd(5'd0, 32'h0, "unimpl_0");
`ifndef CP0_COUNT_EN
        mtc0(5'd9, 32'h1234);
        rd(5'd9, 32'h0, "no_count");
        rd(5'd11, 32'h0, "no_compare");
`endif

        // Interrupt beats exception; eret with req takes the req path
        mtc0(5'd12, 32'h0000_0801);
        hw_int = 6'd2; exc_vld = 1'b1; exc_code = 5'd8; eret = 1'b1; vpc = 32'h3020;
        expect_val("prio_req", SEL_REQ, 32'h1);
        drain();
        step();
        idle();
        rd(5'd12, 32'h0000_0803, "prio_sr");
        rd(5'd13, 32'h0000_0800, "prio_cause");
        rd(5'd14, 32'h0000_3020, "prio_epc");

        mtc0(5'd14, 32'hDEAD_BEEF);
        rd(5'd14, 32'hDEAD_BEEF, "epc_rw");
        expect_val("epc_out_reg", SEL_EPC, 32'hDEAD_BEEF);
        drain();

        // Asynchronous reset in the middle of a handler
        #2;
        reset = 1'b0;
        cp0_addr = 5'd12;
        expect_val("areset_sr", SEL_OUT, 32'h0);
        expect_val("areset_epc", SEL_EPC, 32'h0);
        expect_val("areset_req", SEL_REQ, 32'h0);
        drain();
        @(negedge clk);
        reset = 1'b1;
        step();

        // Interrupts masked when IE=0
        mtc0(5'd12, 32'h0000_FC00);
        hw_int = 6'h3F;
        expect_val("ie_mask", SEL_REQ, 32'h0);
        drain();
        idle();
        mtc0(5'd12, 32'h0);

`ifdef CP0_COUNT_EN
        mtc0(5'd9, 32'h0);
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (req) begin
                got = 1'b1;
                break;
            end
            step();
        end
        check("timer_req", {31'b0, got}, 32'h1);
        @(negedge clk);
        step();
        rd(5'd13, 32'h0000_8000, "timer_ip");
        mtc0(5'd11, 32'd100);
        rd(5'd13, 32'h0000_0000, "timer_clr");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
